// File: rtl/pc_pkg.sv
// Shared picoMIPS program-counter definitions: run-control states and PC defaults.
// Also used by the program ROM and the decoder-side immediate extraction.
package pc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_t;

  localparam int unsigned PC_RESET      = 0;
  localparam int          PSIZE_DEFAULT = 6;

endpackage

// File: rtl/pc_sequencer_if.sv
// Decoder/wrapper-facing bundle of the PC sequencer: run control in, PC and status out.
// The master side drives start and the decoder PC-control fields.
interface pc_sequencer_if
  import pc_pkg::*;
#(
  parameter int Psize = PSIZE_DEFAULT,
  parameter int CNT_W = 16
);

  logic             start;
  logic             PCincr;
  logic             PCrelbranch;
  logic [Psize-1:0] Branchaddr;
  logic [Psize-1:0] PCout;
  logic             run;
  logic             halted;
  logic [CNT_W-1:0] icount;

  modport master (
    output start, PCincr, PCrelbranch, Branchaddr,
    input  PCout, run, halted, icount
  );

  modport slave (
    input  start, PCincr, PCrelbranch, Branchaddr,
    output PCout, run, halted, icount
  );

endinterface

// File: rtl/pc_sequencer_next.sv
// Combinational next-PC computation: relative branch beats increment, else hold.
// Also flags branch-to-self (offset zero) and whether an instruction retires.
module pc_next #(
  parameter int Psize = 6
) (
  input  logic [Psize-1:0] i_pc,
  input  logic             i_incr,
  input  logic             i_relbranch,
  input  logic [Psize-1:0] i_offset,
  output logic [Psize-1:0] o_pc_next,
  output logic             o_self_branch,
  output logic             o_retire
);

  // Unsigned add modulo 2^Psize gives the same bits as a signed offset add.
  always_comb begin
    o_pc_next = i_pc;
    if (i_relbranch) begin
      o_pc_next = i_pc + i_offset;
    end else if (i_incr) begin
      o_pc_next = i_pc + Psize'(1);
    end
  end

  assign o_self_branch = i_relbranch && (i_offset == '0);
  assign o_retire      = i_relbranch || i_incr;

endmodule

// File: rtl/pc_sequencer.sv
// picoMIPS program counter and run control: IDLE/RUN/HALT FSM, PC register and
// saturating retired-instruction counter. Outputs come straight from registers.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int Psize = PSIZE_DEFAULT,
  parameter int CNT_W = 16
) (
  input  logic           clk,
  input  logic           reset,
  pc_sequencer_if.slave  bus
);

  localparam logic [Psize-1:0] PC_ZERO = Psize'(PC_RESET);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  pc_state_t        r_state;
  pc_state_t        w_state_next;
  logic [Psize-1:0] r_pc;
  logic [Psize-1:0] w_pc_next;
  logic [Psize-1:0] w_pc_step;
  logic [CNT_W-1:0] r_icount;
  logic [CNT_W-1:0] w_icount_next;
  logic             w_self_branch;
  logic             w_retire;

  pc_next #(.Psize(Psize)) u_next (
    .i_pc          (r_pc),
    .i_incr        (bus.PCincr),
    .i_relbranch   (bus.PCrelbranch),
    .i_offset      (bus.Branchaddr),
    .o_pc_next     (w_pc_step),
    .o_self_branch (w_self_branch),
    .o_retire      (w_retire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_pc     <= PC_ZERO;
      r_icount <= '0;
    end else begin
      r_state  <= w_state_next;
      r_pc     <= w_pc_next;
      r_icount <= w_icount_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_pc_next     = r_pc;
    w_icount_next = r_icount;
    case (r_state)
      IDLE: begin
        w_pc_next = PC_ZERO;
        if (bus.start) begin
          w_state_next  = RUN;
          w_icount_next = '0;
        end
      end
      RUN: begin
        // Restart overrides whatever the decoder presents this cycle.
        if (bus.start) begin
          w_pc_next     = PC_ZERO;
          w_icount_next = '0;
        end else begin
          w_pc_next = w_pc_step;
          if (w_retire && (r_icount != CNT_MAX)) begin
            w_icount_next = r_icount + CNT_W'(1);
          end
          if (w_self_branch) begin
            w_state_next = HALT;
          end
        end
      end
      HALT: begin
        if (bus.start) begin
          w_state_next  = RUN;
          w_pc_next     = PC_ZERO;
          w_icount_next = '0;
        end
      end
      default: begin
        w_state_next  = IDLE;
        w_pc_next     = PC_ZERO;
        w_icount_next = '0;
      end
    endcase
  end

  assign bus.PCout  = r_pc;
  assign bus.run    = (r_state == RUN);
  assign bus.halted = (r_state == HALT);
  assign bus.icount = r_icount;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: main instance Psize=6/CNT_W=16, plus a
// CNT_W=4 instance for counter saturation.
module tb_pc_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_errors = 0;
  int   n_checks = 0;

  always #5 clk = ~clk;

  pc_sequencer_if #(.Psize(6), .CNT_W(16)) bus ();
  pc_sequencer_if #(.Psize(6), .CNT_W(4))  bus4 ();

  pc_sequencer #(.Psize(6), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  pc_sequencer #(.Psize(6), .CNT_W(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if ({bus.PCout, bus.run, bus.halted, bus.icount} !== {6'd0, 1'b0, 1'b0, 16'd0}) begin
        n_errors++;
        $display("FAIL reset[%0d]: got pc=%0d run=%0b halted=%0b icount=%0d, expected pc=0 run=0 halted=0 icount=0",
                 i, bus.PCout, bus.run, bus.halted, bus.icount);
      end
    end
    reset = 1'b0;
    bus.PCincr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if ({bus.PCout, bus.run, bus.halted, bus.icount} !== {6'd0, 1'b0, 1'b0, 16'd0}) begin
        n_errors++;
        $display("FAIL idle_ignore[%0d]: got pc=%0d run=%0b halted=%0b icount=%0d, expected pc=0 run=0 halted=0 icount=0",
                 i, bus.PCout, bus.run, bus.halted, bus.icount);
      end
    end
    bus.PCincr = 1'b0;
  endtask

  task automatic test_sequential();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    n_checks++;
    if ({bus.PCout, bus.run, bus.halted, bus.icount} !== {6'd0, 1'b1, 1'b0, 16'd0}) begin
      n_errors++;
      $display("FAIL start: got pc=%0d run=%0b halted=%0b icount=%0d, expected pc=0 run=1 halted=0 icount=0",
               bus.PCout, bus.run, bus.halted, bus.icount);
    end
    bus.PCincr = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      n_checks++;
      if ({bus.PCout, bus.run, bus.icount} !== {6'(i), 1'b1, 16'(i)}) begin
        n_errors++;
        $display("FAIL seq[%0d]: got pc=%0d run=%0b icount=%0d, expected pc=%0d run=1 icount=%0d",
                 i, bus.PCout, bus.run, bus.icount, i, i);
      end
    end
    bus.PCincr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if ({bus.PCout, bus.run, bus.icount} !== {6'd10, 1'b1, 16'd10}) begin
        n_errors++;
        $display("FAIL stall[%0d]: got pc=%0d run=%0b icount=%0d, expected pc=10 run=1 icount=10",
                 i, bus.PCout, bus.run, bus.icount);
      end
    end
  endtask

  task automatic test_branches();
    // Starts at pc=10, icount=10.
    logic [5:0]  t_addr [8] = '{6'b111101, 6'd31, 6'd24, 6'd5, 6'b111100, 6'd0, 6'd20, 6'd4};
    logic        t_rel  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic        t_inc  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [5:0]  t_pc   [8] = '{6'd7, 6'd38, 6'd62, 6'd3, 6'd63, 6'd0, 6'd20, 6'd24};
    logic [15:0] t_cnt  [8] = '{16'd11, 16'd12, 16'd13, 16'd14, 16'd15, 16'd16, 16'd17, 16'd18};
    for (int i = 0; i < 8; i++) begin
      bus.PCrelbranch = t_rel[i];
      bus.PCincr      = t_inc[i];
      bus.Branchaddr  = t_addr[i];
      step();
      n_checks++;
      if ({bus.PCout, bus.run, bus.halted, bus.icount} !== {t_pc[i], 1'b1, 1'b0, t_cnt[i]}) begin
        n_errors++;
        $display("FAIL branch[%0d]: got pc=%0d run=%0b halted=%0b icount=%0d, expected pc=%0d run=1 halted=0 icount=%0d",
                 i, bus.PCout, bus.run, bus.halted, bus.icount, t_pc[i], t_cnt[i]);
      end
    end
    bus.PCrelbranch = 1'b0;
    bus.PCincr      = 1'b0;
    bus.Branchaddr  = 6'd0;
  endtask

  task automatic test_termination();
    // pc=24, icount=18 on entry; jump back to 15 first.
    bus.PCrelbranch = 1'b1;
    bus.Branchaddr  = 6'b110111;
    step();
    n_checks++;
    if ({bus.PCout, bus.icount} !== {6'd15, 16'd19}) begin
      n_errors++;
      $display("FAIL goto15: got pc=%0d icount=%0d, expected pc=15 icount=19", bus.PCout, bus.icount);
    end
    bus.Branchaddr = 6'd0;
    step();
    bus.PCrelbranch = 1'b0;
    n_checks++;
    if ({bus.PCout, bus.run, bus.halted, bus.icount} !== {6'd15, 1'b0, 1'b1, 16'd20}) begin
      n_errors++;
      $display("FAIL self_branch: got pc=%0d run=%0b halted=%0b icount=%0d, expected pc=15 run=0 halted=1 icount=20",
               bus.PCout, bus.run, bus.halted, bus.icount);
    end
    bus.PCincr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.PCrelbranch = (i == 1);
      bus.Branchaddr  = 6'd3;
      step();
      n_checks++;
      if ({bus.PCout, bus.run, bus.halted, bus.icount} !== {6'd15, 1'b0, 1'b1, 16'd20}) begin
        n_errors++;
        $display("FAIL halt_hold[%0d]: got pc=%0d run=%0b halted=%0b icount=%0d, expected pc=15 run=0 halted=1 icount=20",
                 i, bus.PCout, bus.run, bus.halted, bus.icount);
      end
    end
    bus.PCrelbranch = 1'b0;
    bus.Branchaddr  = 6'd0;
    bus.start       = 1'b1;
    step();
    bus.start = 1'b0;
    n_checks++;
    if ({bus.PCout, bus.run, bus.halted, bus.icount} !== {6'd0, 1'b1, 1'b0, 16'd0}) begin
      n_errors++;
      $display("FAIL halt_restart: got pc=%0d run=%0b halted=%0b icount=%0d, expected pc=0 run=1 halted=0 icount=0",
               bus.PCout, bus.run, bus.halted, bus.icount);
    end
    bus.PCincr = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    // Running from pc=0, icount=0: 31, then 32, 33.
    bus.PCrelbranch = 1'b1;
    bus.Branchaddr  = 6'd31;
    step();
    bus.PCrelbranch = 1'b0;
    bus.Branchaddr  = 6'd0;
    bus.PCincr      = 1'b1;
    step();
    step();
    n_checks++;
    if ({bus.PCout, bus.icount} !== {6'd33, 16'd3}) begin
      n_errors++;
      $display("FAIL goto33: got pc=%0d icount=%0d, expected pc=33 icount=3", bus.PCout, bus.icount);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++;
    if ({bus.PCout, bus.run, bus.halted, bus.icount} !== {6'd0, 1'b0, 1'b0, 16'd0}) begin
      n_errors++;
      $display("FAIL reset_mid_run: got pc=%0d run=%0b halted=%0b icount=%0d, expected pc=0 run=0 halted=0 icount=0",
               bus.PCout, bus.run, bus.halted, bus.icount);
    end
    bus.PCincr = 1'b0;
  endtask

  task automatic test_restart();
    bus.start = 1'b1;
    step();
    bus.start       = 1'b0;
    bus.PCrelbranch = 1'b1;
    bus.Branchaddr  = 6'd31;
    step();
    bus.Branchaddr = 6'd9;
    step();
    bus.PCrelbranch = 1'b0;
    bus.Branchaddr  = 6'd0;
    n_checks++;
    if ({bus.PCout, bus.run, bus.icount} !== {6'd40, 1'b1, 16'd2}) begin
      n_errors++;
      $display("FAIL goto40: got pc=%0d run=%0b icount=%0d, expected pc=40 run=1 icount=2",
               bus.PCout, bus.run, bus.icount);
    end
    bus.start  = 1'b1;
    bus.PCincr = 1'b1;
    step();
    bus.start = 1'b0;
    n_checks++;
    if ({bus.PCout, bus.run, bus.halted, bus.icount} !== {6'd0, 1'b1, 1'b0, 16'd0}) begin
      n_errors++;
      $display("FAIL run_restart: got pc=%0d run=%0b halted=%0b icount=%0d, expected pc=0 run=1 halted=0 icount=0",
               bus.PCout, bus.run, bus.halted, bus.icount);
    end
    step();
    bus.PCincr = 1'b0;
    n_checks++;
    if ({bus.PCout, bus.icount} !== {6'd1, 16'd1}) begin
      n_errors++;
      $display("FAIL after_restart: got pc=%0d icount=%0d, expected pc=1 icount=1", bus.PCout, bus.icount);
    end
  endtask

  task automatic test_saturation();
    bus4.start = 1'b1;
    step();
    bus4.start  = 1'b0;
    bus4.PCincr = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      n_checks++;
      if ({bus4.PCout, bus4.run, bus4.icount} !== {6'(i), 1'b1, 4'((i > 15) ? 15 : i)}) begin
        n_errors++;
        $display("FAIL saturate[%0d]: got pc=%0d run=%0b icount=%0d, expected pc=%0d run=1 icount=%0d",
                 i, bus4.PCout, bus4.run, bus4.icount, i, (i > 15) ? 15 : i);
      end
    end
    bus4.PCincr = 1'b0;
  endtask

  initial begin
    bus.start        = 1'b0;
    bus.PCincr       = 1'b0;
    bus.PCrelbranch  = 1'b0;
    bus.Branchaddr   = '0;
    bus4.start       = 1'b0;
    bus4.PCincr      = 1'b0;
    bus4.PCrelbranch = 1'b0;
    bus4.Branchaddr  = '0;
    test_reset();
    test_sequential();
    test_branches();
    test_termination();
    test_reset_mid_run();
    test_restart();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program counter and run-control stage for picoMIPS. It sits directly downstream of the instruction decoder and consumes the decoder's PC-control outputs, PCincr and PCrelbranch.
- It generates the program-memory address each cycle, applies PC-relative branches and detects the branch-to-self program terminator.
- It exposes start/halt handshake signals and a retired-instruction counter for the board-level wrapper.

Parameters:
- Psize, 6, program counter and branch offset width in bits (program memory depth 2^Psize).
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse: begin or restart execution from address 0.
- PCincr  input  1  from decoder: advance PC by 1.
- PCrelbranch  input  1  from decoder: PC-relative branch taken.
- Branchaddr  input  Psize  two's-complement branch offset, taken from the instruction immediate field.
- PCout  output  Psize  current program-memory address.
- run  output  1  high while executing; gates register-file writes upstream.
- halted  output  1  high after the program terminates via branch-to-self.
- icount  output  CNT_W  instructions retired since the last start; saturating.

Behaviour:
- Clocking and reset:
  - Single clock domain; all state updates on posedge clk.
  - reset has priority over every other input, including mid-execution. It forces state=IDLE, PCout=0, run=0, halted=0, icount=0.
- States: IDLE, RUN, HALT. run=1 only in RUN. halted=1 only in HALT. Both outputs are registered or decoded directly from the state register, with no combinational path from inputs.
- IDLE:
  - PCout holds 0; PCincr and PCrelbranch are ignored.
  - start=1 -> RUN next cycle with PCout=0 and icount=0.
- RUN, evaluated every cycle in this priority order:
  1. start=1: restart. PCout<=0, icount<=0, stay in RUN; decoder inputs are ignored this cycle.
  2. PCrelbranch=1 and Branchaddr==0: branch-to-self. -> HALT, PCout held, icount increments.
  3. PCrelbranch=1: PCout <= PCout + Branchaddr, where Branchaddr is treated as signed. The sum is taken modulo 2^Psize, so it wraps both ways. icount increments.
  4. PCincr=1: PCout <= PCout + 1, modulo 2^Psize (max address -> 0). icount increments.
  5. Neither: PCout held (stall); icount unchanged.
- Simultaneous PCincr and PCrelbranch: PCrelbranch wins (case 3 beats case 4). This is not an error.
- icount saturates at 2^CNT_W-1 and never wraps.
- HALT:
  - PCout holds the terminating address; decoder inputs are ignored; icount frozen.
  - start=1 -> RUN with PCout=0, icount=0, halted=0 next cycle.
- Latency: the PC update is visible on PCout one clock after the decoder inputs are sampled. The branch target is computed from the current PCout, i.e. the address of the branch instruction.
- No X propagation: any illegal state encoding -> IDLE on the next clock.

Decomposition:
- Shared package pc_pkg holds:
  - typedef enum logic [1:0] pc_state_t {IDLE, RUN, HALT};
  - localparam PC_RESET = '0;
  - the default Psize, shared with the program ROM and decoder-side immediate extraction.
- Sub-module pc_next (combinational): takes PCout, PCincr, PCrelbranch and Branchaddr, and returns the next PC plus a self_branch flag.
- The FSM, PC register and icount live in pc_sequencer.

Test Plan (Psize=6, CNT_W=16):
- Reset, then idle: assert reset 2 cycles, drive PCincr=1 for 5 cycles without start -> PCout=0, run=0, halted=0, icount=0 throughout.
- Sequential run: start pulse, PCincr=1 for 10 cycles -> PCout reaches 10, icount=10, run=1. Hold PCincr=0 for 3 cycles -> PCout stays 10, icount stays 10.
- Branches:
  - At PCout=10, PCrelbranch=1, Branchaddr=6'b111101 (-3) -> PCout=7 next cycle.
  - At PCout=62, Branchaddr=5 -> PCout=3 (wrap).
  - At PCout=63, PCincr -> PCout=0.
  - PCincr and PCrelbranch both high with offset 4 at PCout=20 -> PCout=24.
- Termination: at PCout=15, PCrelbranch=1, Branchaddr=0 -> next cycle halted=1, run=0, PCout=15, icount incremented by 1. Further PCincr pulses leave PCout at 15. Then a start pulse -> RUN, PCout=0, icount=0, halted=0.
- Reset and restart mid-run:
  - Assert reset at PCout=33 while PCincr=1 -> next cycle PCout=0, IDLE, icount=0.
  - A start pulse during RUN at PCout=40 -> PCout=0, icount=0, and the concurrent PCincr is ignored.
- Saturation (CNT_W=4 override): start, PCincr=1 for 20 cycles -> icount stops at 15 while PCout reaches 20.
